// File: rtl/sha256_pkg.sv
// SHA-256 shared constants, FSM state type and the FIPS 180-4 logical functions.
// Imported by the iterative core and its single-round datapath.
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Element 0 sits in the most significant word, so IV maps straight onto o_digest.
    localparam logic [0:7][31:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [0:63][31:0] K = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round: working variables a..h in, W and K
// consumed, next a..h out. a occupies the top 32 bits of the state vector.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [255:0] st_in,
    input  logic [31:0]  w,
    input  logic [31:0]  k,
    output logic [255:0] st_out
);

    logic [31:0] a, b, c, d, e, f, g, h;
    logic [31:0] t1, t2;

    assign {a, b, c, d, e, f, g, h} = st_in;

    assign t1 = h + big_sigma1(e) + ch(e, f, g) + k + w;
    assign t2 = big_sigma0(a) + maj(a, b, c);

    assign st_out = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_iter_core.sv
// Iterative SHA-256 block compressor: ROUNDS_PER_CYCLE rounds per clock over a sliding
// 16-word schedule window, with the chaining digest kept in-core between blocks.
module sha256_iter_core
    import sha256_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int OUT_REG          = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         i_ready,
    input  logic         i_first,
    input  logic [511:0] i_data,
    output logic         o_valid,
    input  logic         o_ready,
    output logic [255:0] o_digest
);

    localparam int R = ROUNDS_PER_CYCLE;

    if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rounds_per_cycle
        $error("sha256_iter_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
    end

    if (OUT_REG != 1) begin : g_bad_out_reg
        $error("sha256_iter_core: OUT_REG=0 is reserved");
    end

    state_e            state_q, state_d;
    logic [6:0]        cnt_q;
    logic [0:7][31:0]  h_q;
    logic [0:7][31:0]  wv_q;
    logic [0:15][31:0] w_q;
    logic [0:15][31:0] w_nxt;
    logic [255:0]      rnd_out;
    logic              accept;
    logic              last_step;

    // Produces the next R schedule words; later words may depend on earlier new ones.
    function automatic logic [0:15][31:0] next_window(input logic [0:15][31:0] w);
        logic [31:0]       ext [0:23];
        logic [0:15][31:0] res;
        for (int i = 0; i < 24; i++) ext[i] = '0;
        for (int i = 0; i < 16; i++) ext[i] = w[i];
        for (int j = 0; j < R; j++) begin
            ext[16+j] = small_sigma1(ext[14+j]) + ext[9+j] + small_sigma0(ext[1+j]) + ext[j];
        end
        for (int i = 0; i < 16; i++) res[i] = ext[i+R];
        return res;
    endfunction

    assign w_nxt     = next_window(w_q);
    assign accept    = i_valid & i_ready;
    assign last_step = (cnt_q == 7'(64 - R));

    for (genvar r = 0; r < R; r++) begin : g_rnd
        logic [255:0] st_in;
        logic [255:0] st_out;
        if (r == 0) begin : g_head
            assign st_in = wv_q;
        end else begin : g_link
            assign st_in = g_rnd[r-1].st_out;
        end
        sha256_round u_round (
            .st_in  (st_in),
            .w      (w_q[r]),
            .k      (K[cnt_q[5:0] + 6'(r)]),
            .st_out (st_out)
        );
    end

    assign rnd_out = g_rnd[R-1].st_out;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (accept)    state_d = ST_ROUND;
            ST_ROUND: if (last_step) state_d = ST_FINAL;
            ST_FINAL:                state_d = ST_DONE;
            ST_DONE:  if (o_ready)   state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // Ready is held low through reset so nothing is taken while state is being cleared.
    always_comb begin
        i_ready = 1'b0;
        o_valid = 1'b0;
        case (state_q)
            ST_IDLE: i_ready = ~rst;
            ST_DONE: o_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            h_q   <= IV;
            wv_q  <= '0;
            w_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        w_q   <= i_data;
                        cnt_q <= '0;
                        // A first block rebases the chain on IV so FINAL can always add h_q.
                        if (i_first) begin
                            h_q  <= IV;
                            wv_q <= IV;
                        end else begin
                            wv_q <= h_q;
                        end
                    end
                end
                ST_ROUND: begin
                    wv_q  <= rnd_out;
                    w_q   <= w_nxt;
                    cnt_q <= cnt_q + 7'(R);
                end
                ST_FINAL: begin
                    for (int j = 0; j < 8; j++) h_q[j] <= h_q[j] + wv_q[j];
                end
                default: ;
            endcase
        end
    end

    assign o_digest = h_q;

endmodule

// File: tb/tb_sha256_iter_core.sv
// Directed bench: four cores (1/2/4/8 rounds per cycle) fed from a vector table, plus
// hand sequences for output stall, same-cycle handoff and reset abort.
module tb_sha256_iter_core;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   i_valid_v;
    logic [3:0]   i_ready_v;
    logic         i_first;
    logic [511:0] i_data;
    logic [3:0]   o_valid_v;
    logic [3:0]   o_ready_v;
    logic [255:0] dig_v [4];

    int checks   = 0;
    int failures = 0;

    localparam logic [511:0] BLK_ABC   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] BLK_EMPTY = {32'h80000000, {15{32'h0}}};
    localparam logic [511:0] BLK_TWO1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_TWO2  = {{15{32'h0}}, 32'h000001c0};

    localparam logic [255:0] DIG_ABC   =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO   =
        256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [255:0] DIG_EMPTY =
        256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] DIG_IV    =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        sha256_iter_core #(
            .ROUNDS_PER_CYCLE (1 << g),
            .OUT_REG          (1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .i_valid  (i_valid_v[g]),
            .i_ready  (i_ready_v[g]),
            .i_first  (i_first),
            .i_data   (i_data),
            .o_valid  (o_valid_v[g]),
            .o_ready  (o_ready_v[g]),
            .o_digest (dig_v[g])
        );
    end

    typedef struct {
        int           dut;
        bit           first;
        logic [511:0] data;
        logic [255:0] exp;
        bit           chk_dig;
        string        tag;
    } vec_t;

    vec_t vecs [20];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic wait_valid(input int k, output int lat);
        lat = 0;
        while (!o_valid_v[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_block(input int k, input bit first, input logic [511:0] data,
                             input logic [255:0] exp, input bit chk_dig, input string tag);
        int n;
        int lat;
        n = 0;
        @(negedge clk);
        while (!i_ready_v[k] && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, 256'(i_ready_v[k]), 256'(1));
        i_valid_v[k] = 1'b1;
        i_first      = first;
        i_data       = data;
        @(posedge clk); #1;
        i_valid_v[k] = 1'b0;
        chk({tag, "_busy"}, 256'(i_ready_v[k]), 256'(0));
        wait_valid(k, lat);
        chk({tag, "_latency"}, 256'(lat), 256'(64 / (1 << k) + 1));
        if (chk_dig) chk({tag, "_digest"}, dig_v[k], exp);
        o_ready_v[k] = 1'b1;
        @(posedge clk); #1;
        o_ready_v[k] = 1'b0;
        chk({tag, "_handoff_valid"}, 256'(o_valid_v[k]), 256'(0));
        chk({tag, "_handoff_ready"}, 256'(i_ready_v[k]), 256'(1));
        if (chk_dig) chk({tag, "_persist"}, dig_v[k], exp);
    endtask

    initial begin
        int  lat;
        bit  stable;
        bit  rdy_seen;
        bit  vld_drop;
        bit  spur;

        rst       = 1'b1;
        i_valid_v = '0;
        o_ready_v = '0;
        i_first   = 1'b0;
        i_data    = '0;

        for (int g = 0; g < 4; g++) begin
            vecs[g*5+0] = '{g, 1'b1, BLK_ABC,   DIG_ABC,   1'b1, $sformatf("abc_r%0d", 1 << g)};
            vecs[g*5+1] = '{g, 1'b1, BLK_TWO1,  '0,        1'b0, $sformatf("two1_r%0d", 1 << g)};
            vecs[g*5+2] = '{g, 1'b0, BLK_TWO2,  DIG_TWO,   1'b1, $sformatf("two2_r%0d", 1 << g)};
            vecs[g*5+3] = '{g, 1'b1, BLK_EMPTY, DIG_EMPTY, 1'b1, $sformatf("empty_r%0d", 1 << g)};
            vecs[g*5+4] = '{g, 1'b1, BLK_ABC,   DIG_ABC,   1'b1, $sformatf("b2b_abc_r%0d", 1 << g)};
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_i_ready", 256'(i_ready_v), 256'(0));
        chk("rst_o_valid", 256'(o_valid_v), 256'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_i_ready", 256'(i_ready_v), 256'(4'hf));
        chk("post_rst_digest_iv", dig_v[0], DIG_IV);

        for (int v = 0; v < 20; v++) begin
            run_block(vecs[v].dut, vecs[v].first, vecs[v].data, vecs[v].exp,
                      vecs[v].chk_dig, vecs[v].tag);
        end

        // Output stall with a block offered, then same-cycle handoff and new offer.
        @(negedge clk);
        i_valid_v[0] = 1'b1;
        i_first      = 1'b1;
        i_data       = BLK_ABC;
        @(posedge clk); #1;
        i_valid_v[0] = 1'b0;
        wait_valid(0, lat);
        chk("stall_first_latency", 256'(lat), 256'(65));
        i_valid_v[0] = 1'b1;
        i_data       = BLK_EMPTY;
        stable   = 1'b1;
        rdy_seen = 1'b0;
        vld_drop = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (dig_v[0] !== DIG_ABC) stable = 1'b0;
            if (i_ready_v[0]) rdy_seen = 1'b1;
            if (!o_valid_v[0]) vld_drop = 1'b1;
        end
        chk("stall_digest_stable", 256'(stable), 256'(1));
        chk("stall_i_ready_low", 256'(rdy_seen), 256'(0));
        chk("stall_o_valid_held", 256'(vld_drop), 256'(0));
        o_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        o_ready_v[0] = 1'b0;
        chk("samecyc_o_valid", 256'(o_valid_v[0]), 256'(0));
        chk("samecyc_not_accepted", 256'(i_ready_v[0]), 256'(1));
        @(posedge clk); #1;
        i_valid_v[0] = 1'b0;
        chk("samecyc_accepted_next", 256'(i_ready_v[0]), 256'(0));
        wait_valid(0, lat);
        chk("samecyc_latency", 256'(lat), 256'(65));
        chk("samecyc_digest", dig_v[0], DIG_EMPTY);
        o_ready_v[0] = 1'b1;
        @(posedge clk); #1;
        o_ready_v[0] = 1'b0;

        // Reset abort around round 30, then resend abc chained (i_first=0) from restored IV.
        @(negedge clk);
        i_valid_v[0] = 1'b1;
        i_first      = 1'b1;
        i_data       = BLK_ABC;
        @(posedge clk); #1;
        i_valid_v[0] = 1'b0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_rst_i_ready", 256'(i_ready_v[0]), 256'(0));
        rst  = 1'b0;
        spur = 1'b0;
        repeat (80) begin
            @(posedge clk); #1;
            if (o_valid_v[0]) spur = 1'b1;
        end
        chk("abort_no_spurious_valid", 256'(spur), 256'(0));
        chk("abort_digest_iv", dig_v[0], DIG_IV);
        run_block(0, 1'b0, BLK_ABC, DIG_ABC, 1'b1, "abort_resend");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
